mn_matrix_stream: RTL

//  Parametrised M x N matrix store for the predictor-corrector datapath, with runtime dimensions.

---
 rtl/mn_matrix_stream_if.sv | 51 +++++
 rtl/mn_matrix_stream.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mn_matrix_stream_if.sv
// Bus bundle for mn_matrix_stream: configuration, random write port,
// command/status handshake and the valid/ready streaming output.
interface mn_matrix_stream_if #(
    parameter int DATA_W = 32,
    parameter int MW     = 7,
    parameter int NW     = 7
) ();

    // Runtime dimensions, latched by the store when a command is accepted
    logic [MW:0]       m_dim;
    logic [NW:0]       n_dim;

    // Single-word write port
    logic              write;
    logic [MW-1:0]     m_addr;
    logic [NW-1:0]     n_addr;
    logic [DATA_W-1:0] data_in;
    logic              wr_err;

    // Commands and status
    logic              start;
    logic              transpose;
    logic              clear;
    logic              cmd_err;
    logic              busy;
    logic              done;

    // Streaming read-out
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_eol;
    logic              out_last;

    // Producer of commands/writes and consumer of the stream
    modport master (
        output m_dim, n_dim, write, m_addr, n_addr, data_in,
        output start, transpose, clear, out_ready,
        input  wr_err, cmd_err, busy, done,
        input  out_valid, out_data, out_eol, out_last
    );

    // The matrix store itself
    modport slave (
        input  m_dim, n_dim, write, m_addr, n_addr, data_in,
        input  start, transpose, clear, out_ready,
        output wr_err, cmd_err, busy, done,
        output out_valid, out_data, out_eol, out_last
    );

endinterface

// File: rtl/mn_matrix_stream.sv
// M x N matrix store with runtime dimensions. Random single-word writes
// while idle, a hardware zero-fill sweep of the active region, and a
// full-matrix stream (row-major or transposed) over valid/ready with
// end-of-line and end-of-matrix markers.
module mn_matrix_stream #(
    parameter int DATA_W = 32,
    parameter int MAX_M  = 128,
    parameter int MAX_N  = 128,
    parameter int MW     = $clog2(MAX_M),
    parameter int NW     = $clog2(MAX_N)
) (
    input  logic               clk,
    input  logic               reset,
    mn_matrix_stream_if.slave  bus
);

    localparam int AW    = MW + NW;
    localparam int DEPTH = MAX_M * MAX_N;

    localparam logic [MW:0] MAX_M_V = (MW+1)'(MAX_M);
    localparam logic [NW:0] MAX_N_V = (NW+1)'(MAX_N);
    localparam logic [MW:0] ONE_M   = (MW+1)'(1);
    localparam logic [NW:0] ONE_N   = (NW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM
    } state_t;

    // A command is only legal with non-zero dims that fit the array
    function automatic logic dims_ok(input logic [MW:0] m, input logic [NW:0] n);
        return (m != '0) && (n != '0) && (m <= MAX_M_V) && (n <= MAX_N_V);
    endfunction

    state_t            state;
    state_t            state_nxt;

    // Dimensions and order latched with the accepted command
    logic [MW:0]       m_lat;
    logic [NW:0]       n_lat;
    logic              tr_lat;
    logic [MW:0]       m_term;
    logic [NW:0]       n_term;

    // Sweep position shared by clear and stream
    logic [MW-1:0]     ci;
    logic [NW-1:0]     cj;
    logic              ci_term;
    logic              cj_term;
    logic              at_last;
    logic              row_major;
    logic              step;
    logic              rd_all;

    // Command decode
    logic              idle;
    logic              cmd_ok;
    logic              go_clear;
    logic              go_stream;
    logic              cmd_bad;
    logic              wr_ok;

    // Storage ports
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en_p0;
    logic [AW-1:0]     rd_addr_p0;

    // Read result, one cycle behind the issue
    logic [DATA_W-1:0] rd_data_p1;
    logic              vld_p1;
    logic              eol_p1;
    logic              last_p1;

    // Two-entry output buffer
    logic [DATA_W-1:0] buf_data_p2 [2];
    logic [1:0]        buf_eol_p2;
    logic [1:0]        buf_last_p2;
    logic [1:0]        buf_cnt;
    logic              buf_wp;
    logic              buf_rp;
    logic              push;
    logic              pop;
    logic [1:0]        occ;
    logic              head_last;

    // Status registers
    logic              wr_err_r;
    logic              cmd_err_r;
    logic              done_r;

    assign idle      = (state == S_IDLE);
    assign cmd_ok    = dims_ok(bus.m_dim, bus.n_dim);
    assign go_clear  = idle && bus.clear && cmd_ok;
    assign go_stream = idle && !bus.clear && bus.start && cmd_ok;
    // clear shadows start; anything arriving while busy is refused
    assign cmd_bad   = idle ? ((bus.clear && !cmd_ok) || (!bus.clear && bus.start && !cmd_ok))
                            : (bus.start || bus.clear);
    // Writes are bounded by the live dims, not the latched ones
    assign wr_ok     = idle && bus.write
                       && ({1'b0, bus.m_addr} < bus.m_dim)
                       && ({1'b0, bus.n_addr} < bus.n_dim);

    assign m_term    = m_lat - ONE_M;
    assign n_term    = n_lat - ONE_N;
    assign ci_term   = ({1'b0, ci} == m_term);
    assign cj_term   = ({1'b0, cj} == n_term);
    assign at_last   = ci_term && cj_term;
    // The clear sweep is always row-major; the stream follows the latched order
    assign row_major = (state == S_CLEAR) || !tr_lat;

    // Buffer accounting: a slot is free if held entries plus the in-flight
    // read, less the one leaving this cycle, leave room for another word
    assign push      = vld_p1;
    assign pop       = (buf_cnt != 2'd0) && bus.out_ready;
    assign occ       = buf_cnt + {1'b0, vld_p1};
    assign head_last = buf_last_p2[buf_rp];

    assign rd_en_p0   = (state == S_STREAM) && !rd_all && ((occ - {1'b0, pop}) < 2'd2);
    assign rd_addr_p0 = {ci, cj};
    assign step       = (state == S_CLEAR) || rd_en_p0;

    assign wr_en   = wr_ok || (state == S_CLEAR);
    assign wr_addr = (state == S_CLEAR) ? {ci, cj} : {bus.m_addr, bus.n_addr};
    assign wr_data = (state == S_CLEAR) ? '0 : bus.data_in;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave IDLE on an accepted command, return when the sweep or stream ends
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (go_clear) begin
                    state_nxt = S_CLEAR;
                end else if (go_stream) begin
                    state_nxt = S_STREAM;
                end
            end
            S_CLEAR: begin
                if (at_last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_STREAM: begin
                if (pop && head_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latch dimensions and order when a command is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            m_lat  <= '0;
            n_lat  <= '0;
            tr_lat <= 1'b0;
        end else if (go_clear || go_stream) begin
            m_lat  <= bus.m_dim;
            n_lat  <= bus.n_dim;
            tr_lat <= go_stream && bus.transpose;
        end
    end

    // Sweep counters: advance once per clear write or per issued read, stop at the final element
    always_ff @(posedge clk) begin
        if (reset) begin
            ci     <= '0;
            cj     <= '0;
            rd_all <= 1'b0;
        end else if (go_clear || go_stream) begin
            ci     <= '0;
            cj     <= '0;
            rd_all <= 1'b0;
        end else if (step) begin
            if (at_last) begin
                rd_all <= 1'b1;
            end else if (row_major) begin
                if (cj_term) begin
                    cj <= '0;
                    ci <= ci + 1'b1;
                end else begin
                    cj <= cj + 1'b1;
                end
            end else begin
                if (ci_term) begin
                    ci <= '0;
                    cj <= cj + 1'b1;
                end else begin
                    ci <= ci + 1'b1;
                end
            end
        end
    end

    // Array write port: host writes in IDLE, zero-fill in CLEAR
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ---- p0 -> p1: synchronous array read with its markers ----
    always_ff @(posedge clk) begin
        if (rd_en_p0) begin
            rd_data_p1 <= mem[rd_addr_p0];
            eol_p1     <= row_major ? cj_term : ci_term;
            last_p1    <= at_last;
        end
    end

    // Read-valid travels alongside the read data
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_en_p0;
        end
    end

    // ---- p1 -> p2: output buffer payload ----
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_p2[buf_wp] <= rd_data_p1;
            buf_eol_p2[buf_wp]  <= eol_p1;
            buf_last_p2[buf_wp] <= last_p1;
        end
    end

    // Output buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_cnt <= 2'd0;
            buf_wp  <= 1'b0;
            buf_rp  <= 1'b0;
        end else begin
            if (push) begin
                buf_wp <= ~buf_wp;
            end
            if (pop) begin
                buf_rp <= ~buf_rp;
            end
            buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Single-cycle status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err_r  <= 1'b0;
            cmd_err_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            wr_err_r  <= bus.write && !wr_ok;
            cmd_err_r <= cmd_bad;
            done_r    <= (state != S_IDLE) && (state_nxt == S_IDLE);
        end
    end

    assign bus.wr_err    = wr_err_r;
    assign bus.cmd_err   = cmd_err_r;
    assign bus.done      = done_r;
    assign bus.busy      = (state != S_IDLE);
    assign bus.out_valid = (buf_cnt != 2'd0);
    assign bus.out_data  = bus.out_valid ? buf_data_p2[buf_rp] : '0;
    assign bus.out_eol   = bus.out_valid && buf_eol_p2[buf_rp];
    assign bus.out_last  = bus.out_valid && buf_last_p2[buf_rp];

endmodule
